// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters: round-robin grant in IDLE,
// one EXEC cycle driven from registered operands, then a held response until consumed.
module alu_share_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_ctr,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_ctr,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_shamt,
  output logic [4:0]  alu_ctr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_ovf,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        prio;
  logic        op_id;
  logic [4:0]  op_ctr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op_shamt;
  logic        grant_any;
  logic        grant_id;
  logic        op_unsup;

  // Grant is combinational so a requester sees ready in the same IDLE cycle;
  // held off while reset is asserted.
  always_comb begin
    grant_any = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    grant_id  = (req0_valid && req1_valid) ? prio : req1_valid;
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;

  assign op_unsup = (op_ctr == 5'b01010) || (op_ctr == 5'b01011) || (op_ctr > 5'b10000);

  assign alu_ctr   = op_ctr;
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_shamt = op_shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      op_id       <= 1'b0;
      op_ctr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_shamt    <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_ovf    <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_ctr   <= grant_id ? req1_ctr   : req0_ctr;
            op_a     <= grant_id ? req1_a     : req0_a;
            op_b     <= grant_id ? req1_b     : req0_b;
            op_shamt <= grant_id ? req1_shamt : req0_shamt;
            op_id    <= grant_id;
            prio     <= ~grant_id;
            state    <= EXEC;
          end
        end
        EXEC: begin
          resp_valid <= 1'b1;
          resp_id    <= op_id;
          // Unsupported codes report a clean zero result instead of whatever the ALU produced.
          if (op_unsup) begin
            resp_result <= '0;
            resp_zero   <= 1'b1;
            resp_ovf    <= 1'b0;
            resp_err    <= 1'b1;
          end else begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_ovf    <= alu_overflow;
            resp_err    <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU stub on the alu_* side.
module tb_alu_share_arb;

  localparam logic [4:0] ADDU = 5'd0, SUBU = 5'd2, AND_ = 5'd4, OR_ = 5'd5, XOR_ = 5'd6;
  localparam logic [4:0] SLL = 5'd12, SRA = 5'd14, LUI = 5'd15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_ctr, req1_ctr, req0_shamt, req1_shamt;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  alu_ctr, alu_shamt;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero, alu_overflow;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_ovf, resp_err;
  logic [31:0] resp_result;

  int tests_run = 0;
  int tests_failed = 0;

  // Stream scratch: per-port op lists in, observed grants/responses out.
  logic [4:0]  s_ctr [2][8];
  logic [31:0] s_a   [2][8];
  logic [31:0] s_b   [2][8];
  logic [4:0]  s_sh  [2][8];
  int          s_n   [2];
  int          g_id  [16];
  logic [35:0] r_obs [16];
  int          n_grant, n_resp, both_ready_seen;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctr(req0_ctr),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctr(req1_ctr),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_ovf(resp_ovf), .resp_err(resp_err)
  );

  // Behavioural ALU; unknown codes return junk so the arbiter's masking is visible.
  function automatic logic [32:0] alu_f(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sh);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (c)
      5'd0:  r = a + b;
      5'd1:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd2:  r = a - b;
      5'd3:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd4:  r = a & b;
      5'd5:  r = a | b;
      5'd6:  r = a ^ b;
      5'd7:  r = ~(a | b);
      5'd8:  r = {31'b0, $signed(a) < $signed(b)};
      5'd9:  r = {31'b0, a < b};
      5'd12: r = b << sh;
      5'd13: r = b >> sh;
      5'd14: r = $signed(b) >>> sh;
      5'd15: r = {b[15:0], 16'h0};
      5'd16: r = b;
      default: begin r = 32'hDEADBEEF; v = 1'b1; end
    endcase
    return {v, r};
  endfunction

  // Expected {zero, ovf, err, result} for one request.
  function automatic logic [34:0] ref_resp(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh);
    logic [32:0] r;
    if (c == 5'd10 || c == 5'd11 || c > 5'd16) return {1'b1, 1'b0, 1'b1, 32'h0};
    r = alu_f(c, a, b, sh);
    return {r[31:0] == 32'h0, r[32], 1'b0, r[31:0]};
  endfunction

  always_comb begin
    {alu_overflow, alu_result} = alu_f(alu_ctr, alu_a, alu_b, alu_shamt);
    alu_zero = (alu_result == 32'h0);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issues one op on port p and reports accept latency, response latency and the response.
  task automatic run_op(input logic p, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output int acc, output int rl, output logic [35:0] r);
    @(posedge clk); #1;
    if (p) begin
      req1_valid = 1'b1; req1_ctr = c; req1_a = a; req1_b = b; req1_shamt = sh;
    end else begin
      req0_valid = 1'b1; req0_ctr = c; req0_a = a; req0_b = b; req0_shamt = sh;
    end
    acc = -1; rl = -1; r = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p ? req1_ready : req0_ready) === 1'b1) begin acc = i; break; end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        rl = i;
        r = {resp_id, resp_zero, resp_ovf, resp_err, resp_result};
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Keeps every port with pending ops valid and records grant order and responses.
  task automatic run_stream();
    int idx0, idx1;
    idx0 = 0; idx1 = 0; n_grant = 0; n_resp = 0; both_ready_seen = 0;
    for (int cyc = 0; cyc < 200 && n_resp < s_n[0] + s_n[1]; cyc++) begin
      @(posedge clk); #1;
      req0_valid = (idx0 < s_n[0]);
      req1_valid = (idx1 < s_n[1]);
      if (req0_valid) begin
        req0_ctr = s_ctr[0][idx0]; req0_a = s_a[0][idx0]; req0_b = s_b[0][idx0]; req0_shamt = s_sh[0][idx0];
      end
      if (req1_valid) begin
        req1_ctr = s_ctr[1][idx1]; req1_a = s_a[1][idx1]; req1_b = s_b[1][idx1]; req1_shamt = s_sh[1][idx1];
      end
      @(negedge clk);
      if (req0_ready && req1_ready) both_ready_seen++;
      if (req0_ready === 1'b1 && n_grant < 16) begin g_id[n_grant] = 0; n_grant++; idx0++; end
      else if (req1_ready === 1'b1 && n_grant < 16) begin g_id[n_grant] = 1; n_grant++; idx1++; end
      if (resp_valid === 1'b1 && n_resp < 16) begin
        r_obs[n_resp] = {resp_id, resp_zero, resp_ovf, resp_err, resp_result};
        n_resp++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b1; req0_ctr = ADDU; req0_a = 32'd1; req0_b = 32'd1; req0_shamt = 5'd0;
    req1_valid = 1'b1; req1_ctr = ADDU; req1_a = 32'd2; req1_b = 32'd2; req1_shamt = 5'd0;
    #12;
    tests_run++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_zero, resp_ovf, resp_err,
         alu_ctr, alu_a, alu_b, alu_shamt} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: outputs not all zero (ready %b%b valid %b alu_a %h)",
               req0_ready, req1_ready, resp_valid, alu_a);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({req0_ready, req1_ready, resp_valid} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_grant: got %b expected 100", {req0_ready, req1_ready, resp_valid});
    end
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_ctr = ADDU; req0_a = 32'd5; req0_b = 32'd7; req0_shamt = 5'd0;
    @(negedge clk);
    tests_run++;
    if ({req0_ready, req1_ready, resp_valid} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL single_accept: got %b expected 100", {req0_ready, req1_ready, resp_valid});
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({resp_valid, alu_ctr, alu_a, alu_b} !== {1'b0, ADDU, 32'd5, 32'd7}) begin
      tests_failed++;
      $display("[TB] FAIL single_exec: valid %b ctr %h a %h b %h expected 0 00 5 7",
               resp_valid, alu_ctr, alu_a, alu_b);
    end
    @(negedge clk);
    tests_run++;
    if ({resp_valid, resp_id, resp_zero, resp_ovf, resp_err, resp_result} !== {5'b10000, 32'd12}) begin
      tests_failed++;
      $display("[TB] FAIL single_resp: got v%b id%b z%b o%b e%b %h expected 1 0 0 0 0 0000000c",
               resp_valid, resp_id, resp_zero, resp_ovf, resp_err, resp_result);
    end
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_release: resp_valid %b expected 0", resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] rdy_pat, vld_pat;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_ctr = ADDU; req0_a = 32'd1; req0_b = 32'd2; req0_shamt = 5'd0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rdy_pat[c] = req0_ready;
      vld_pat[c] = resp_valid;
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    tests_run++;
    if (rdy_pat !== 9'b001001001) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ready_pattern: got %b expected 001001001", rdy_pat);
    end
    tests_run++;
    if (vld_pat !== 9'b100100100) begin
      tests_failed++;
      $display("[TB] FAIL b2b_valid_pattern: got %b expected 100100100", vld_pat);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_ctr = SLL; req0_a = 32'd0; req0_b = 32'd1; req0_shamt = 5'd4;
    @(negedge clk);
    tests_run++;
    if (req0_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_accept: req0_ready %b expected 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_ctr = XOR_; req1_a = 32'hFF00; req1_b = 32'h0FF0; req1_shamt = 5'd0;
    @(negedge clk);
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL bp_exec_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if ({resp_valid, resp_id, resp_err, resp_result, req0_ready, req1_ready} !== {3'b100, 32'h10, 2'b00}) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold cycle %0d: v%b id%b e%b %h rdy %b%b expected 1 0 0 00000010 00",
                 k, resp_valid, resp_id, resp_err, resp_result, req0_ready, req1_ready);
      end
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({resp_valid, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL bp_last_resp: got %b expected 10", {resp_valid, req1_ready});
    end
    @(negedge clk);
    tests_run++;
    if ({resp_valid, req1_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL bp_idle_after: got %b expected 01", {resp_valid, req1_ready});
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({resp_valid, resp_id, resp_result} !== {2'b11, 32'h0000F0F0}) begin
      tests_failed++;
      $display("[TB] FAIL bp_queued_resp: v%b id%b %h expected 1 1 0000f0f0", resp_valid, resp_id, resp_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsupported();
    int acc, rl;
    logic [35:0] r;
    run_op(1'b1, 5'b01010, 32'd3, 32'd4, 5'd0, acc, rl, r);
    tests_run++;
    if ({acc, rl} !== {32'd0, 32'd2}) begin
      tests_failed++;
      $display("[TB] FAIL unsup_latency: accept %0d resp %0d expected 0 2", acc, rl);
    end
    tests_run++;
    if (r !== {4'b1101, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL unsup_resp: got %h expected %h", r, {4'b1101, 32'h0});
    end
    run_op(1'b1, SRA, 32'd0, 32'h80000000, 5'd4, acc, rl, r);
    tests_run++;
    if (r !== {4'b1000, 32'hF8000000}) begin
      tests_failed++;
      $display("[TB] FAIL sra_resp: got %h expected %h", r, {4'b1000, 32'hF8000000});
    end
  endtask

  task automatic test_codes();
    logic [4:0]  codes [7] = '{5'd9, 5'd10, 5'd11, 5'd12, 5'd16, 5'd17, 5'd31};
    logic [31:0] exp_res [7] = '{32'd1, 32'd0, 32'd0, 32'd10, 32'd5, 32'd0, 32'd0};
    logic        exp_err [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int acc, rl;
    logic [35:0] r;
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, codes[i], 32'd3, 32'd5, 5'd1, acc, rl, r);
      tests_run++;
      if (r !== {1'b0, exp_err[i], 1'b0, exp_err[i], exp_res[i]}) begin
        tests_failed++;
        $display("[TB] FAIL code_%0d: got %h expected %h", codes[i], r,
                 {1'b0, exp_err[i], 1'b0, exp_err[i], exp_res[i]});
      end
    end
  endtask

  task automatic test_reset_in_flight();
    int seen;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_ctr = LUI; req0_a = 32'd0; req0_b = 32'h1234; req0_shamt = 5'd0;
    @(negedge clk);
    tests_run++;
    if (req0_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rif_accept: req0_ready %b expected 1", req0_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({resp_valid, alu_ctr, alu_b} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rif_async_clear: v%b ctr %h b %h expected all 0", resp_valid, alu_ctr, alu_b);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rif_no_resp: saw %0d response cycles expected 0", seen);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_ctr = ADDU; req0_a = 32'd2; req0_b = 32'd3; req0_shamt = 5'd0;
    req1_valid = 1'b1; req1_ctr = ADDU; req1_a = 32'd4; req1_b = 32'd4; req1_shamt = 5'd0;
    @(negedge clk);
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL rif_prio: got %b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({resp_valid, resp_id, resp_result} !== {2'b10, 32'd5}) begin
      tests_failed++;
      $display("[TB] FAIL rif_next_resp: v%b id%b %h expected 1 0 00000005", resp_valid, resp_id, resp_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [35:0] exp_r [4] = '{{4'b0100, 32'h0}, {4'b1000, 32'hFF}, {4'b0000, 32'h2}, {4'b1000, 32'h0F}};
    do_reset();
    s_n[0] = 2; s_n[1] = 2;
    s_ctr[0][0] = SUBU; s_a[0][0] = 32'd9;    s_b[0][0] = 32'd9;    s_sh[0][0] = 5'd0;
    s_ctr[0][1] = ADDU; s_a[0][1] = 32'd1;    s_b[0][1] = 32'd1;    s_sh[0][1] = 5'd0;
    s_ctr[1][0] = OR_;  s_a[1][0] = 32'hF0;   s_b[1][0] = 32'h0F;   s_sh[1][0] = 5'd0;
    s_ctr[1][1] = AND_; s_a[1][1] = 32'hFF;   s_b[1][1] = 32'h0F;   s_sh[1][1] = 5'd0;
    run_stream();
    tests_run++;
    if ({n_grant, n_resp, both_ready_seen} !== {32'd4, 32'd4, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL cont_counts: grants %0d resps %0d both_ready %0d expected 4 4 0",
               n_grant, n_resp, both_ready_seen);
    end
    for (int k = 0; k < 4 && k < n_resp; k++) begin
      tests_run++;
      if (g_id[k] !== (k % 2) || r_obs[k] !== exp_r[k]) begin
        tests_failed++;
        $display("[TB] FAIL cont_%0d: grant %0d resp %h expected grant %0d resp %h",
                 k, g_id[k], r_obs[k], k % 2, exp_r[k]);
      end
    end
  endtask

  task automatic test_random();
    int p, i0, i1, id;
    logic [35:0] exp_r;
    do_reset();
    s_n[0] = 6; s_n[1] = 6;
    for (int q = 0; q < 2; q++) begin
      for (int k = 0; k < 6; k++) begin
        s_ctr[q][k] = 5'($urandom_range(0, 31));
        s_a[q][k]   = $urandom;
        s_b[q][k]   = $urandom;
        s_sh[q][k]  = 5'($urandom_range(0, 31));
      end
    end
    run_stream();
    tests_run++;
    if ({n_grant, n_resp, both_ready_seen} !== {32'd12, 32'd12, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL rand_counts: grants %0d resps %0d both_ready %0d expected 12 12 0",
               n_grant, n_resp, both_ready_seen);
    end
    p = 0; i0 = 0; i1 = 0;
    for (int k = 0; k < n_resp; k++) begin
      if (i0 < s_n[0] && i1 < s_n[1]) id = p;
      else if (i0 < s_n[0]) id = 0;
      else id = 1;
      p = 1 - id;
      if (id == 0) begin
        exp_r = {1'b0, ref_resp(s_ctr[0][i0], s_a[0][i0], s_b[0][i0], s_sh[0][i0])};
        i0++;
      end else begin
        exp_r = {1'b1, ref_resp(s_ctr[1][i1], s_a[1][i1], s_b[1][i1], s_sh[1][i1])};
        i1++;
      end
      tests_run++;
      if (r_obs[k] !== exp_r) begin
        tests_failed++;
        $display("[TB] FAIL rand_%0d: resp %h expected %h", k, r_obs[k], exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_unsupported();
    test_codes();
    test_reset_in_flight();
    test_contention();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
